// File: rtl/gpu_pkg.sv
// Shared GPU pipeline types and defaults.
// Pixel entry layout and framebuffer geometry helpers.
package gpu_pkg;

  localparam int COORD_W       = 10;
  localparam int FB_W_DEF      = 640;
  localparam int FB_H_DEF      = 480;
  localparam int FB_ADDR_W_DEF = 19;
  localparam int COLOR_W_DEF   = 8;

  typedef struct packed {
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [COLOR_W_DEF-1:0] color;
    logic                   last;
  } pix_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } wr_state_t;

  function automatic logic in_bounds(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input int                 w,
    input int                 h
  );
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Parameterised synchronous FIFO, first-word fall-through read.
// Pointers carry an extra wrap bit to tell full from empty.
module pix_fifo #(
  parameter int W     = 29,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: FIFO, clip, linear address, single-beat writes.
// Optional duplicate-pixel suppression with FB_PIXEL_DEDUP_EN.
module fb_pixel_writer
  import gpu_pkg::*;
#(
  parameter int FB_W    = FB_W_DEF,
  parameter int FB_H    = FB_H_DEF,
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = FB_ADDR_W_DEF,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               pix_last,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic               line_done,
  output logic [15:0]        clip_cnt
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               last;
  } ent_t;

  localparam int EW = $bits(ent_t);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

  ent_t          push_e;
  ent_t          head;
  logic [EW-1:0] fifo_q;
  logic          full;
  logic          empty;
  logic          pop;

  wr_state_t state;
  wr_state_t state_n;

  logic              cur_last;
  logic              accept;
  logic              inb;
  logic              dup;
  logic              wr_head;
  logic              hold;
  logic              retire;
  logic [ADDR_W-1:0] lin_addr;

  assign push_e = '{x: pix_x, y: pix_y, color: pix_color, last: pix_last};
  assign head   = ent_t'(fifo_q);

  pix_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (pix_valid),
    .din     (push_e),
    .full    (full),
    .pop     (pop),
    .dout    (fifo_q),
    .empty   (empty)
  );

  assign pix_ready = !full && reset_n;
  assign mem_we    = (state == ST_WRITE);
  assign busy      = !empty || mem_we;
  assign lin_addr  = ADDR_W'(head.y) * FB_W_A + ADDR_W'(head.x);

`ifdef FB_PIXEL_DEDUP_EN
  logic               ded_vld;
  logic [COORD_W-1:0] ded_x;
  logic [COORD_W-1:0] ded_y;
  logic [COLOR_W-1:0] ded_c;

  assign dup = ded_vld && (head.x == ded_x) &&
               (head.y == ded_y) && (head.color == ded_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ded_vld <= 1'b0;
      ded_x   <= '0;
      ded_y   <= '0;
      ded_c   <= '0;
    end else if (pop) begin
      if (wr_head) begin
        ded_vld <= !head.last;
        ded_x   <= head.x;
        ded_y   <= head.y;
        ded_c   <= head.color;
      end else if (head.last) begin
        ded_vld <= 1'b0;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    accept  = mem_we && mem_ready;
    inb     = in_bounds(head.x, head.y, FB_W, FB_H);
    wr_head = inb && !dup;
    // two lasts retiring together would merge their line_done pulses
    hold    = accept && cur_last && !wr_head && head.last;
    pop     = !empty && (!mem_we || accept) && !hold;
    retire  = (accept && cur_last) ||
              (pop && !wr_head && head.last);
    state_n = state;
    if (pop && wr_head) state_n = ST_WRITE;
    else if (accept)    state_n = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cur_last  <= 1'b0;
      line_done <= 1'b0;
      clip_cnt  <= '0;
    end else begin
      state     <= state_n;
      line_done <= retire;
      if (pop && wr_head) begin
        mem_addr  <= lin_addr;
        mem_wdata <= head.color;
        cur_last  <= head.last;
      end
      if (pop && !inb && clip_cnt != 16'hFFFF)
        clip_cnt <= clip_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer with a behavioural pixel model.
// Honours FB_PIXEL_DEDUP_EN in the reference model.
module tb_fb_pixel_writer;
  import gpu_pkg::*;

  localparam int FBW = 640;
  localparam int FBH = 480;
`ifdef FB_PIXEL_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  pix_color;
  logic        pix_last;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        line_done;
  logic [15:0] clip_cnt;

  fb_pixel_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_last  (pix_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .line_done (line_done),
    .clip_cnt  (clip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    bit last;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wcount = 0;
  int   ld_seen = 0;
  int   exp_clip = 0;
  int   exp_lines = 0;
  int   n_push = 0;
  bit   m_dv = 0;
  int   m_x, m_y, m_c;
  bit   rnd_ready = 0;
  logic ready_fixed = 1'b1;

  task automatic check(input string name, input longint act,
                       input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: clip, dedup, then linear address in stream order.
  task automatic model_push(input int x, input int y, input int c,
                            input bit last);
    n_push++;
    if (x >= FBW || y >= FBH) begin
      if (exp_clip < 65535) exp_clip++;
      if (last) begin exp_lines++; m_dv = 0; end
    end else if (DEDUP && m_dv && x == m_x && y == m_y && c == m_c) begin
      if (last) begin exp_lines++; m_dv = 0; end
    end else begin
      expq.push_back('{y * FBW + x, c, last});
      if (last) exp_lines++;
      m_dv = !last;
      m_x = x; m_y = y; m_c = c;
    end
  endtask

  task automatic send(input int x, input int y, input int c,
                      input bit last);
    bit ok = 0;
    pix_x = 10'(x); pix_y = 10'(y);
    pix_color = 8'(c); pix_last = last;
    pix_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (pix_ready) begin
        model_push(x, y, c, last);
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    pix_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  always @(posedge clk) begin
    #2;
    mem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  bit   stall = 0;
  bit   chk_ld = 0;
  int   s_addr, s_data;
  exp_t e;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall  = 0;
      chk_ld = 0;
    end else begin
      if (chk_ld) check("line_done_after_last", line_done, 1);
      chk_ld = 0;
      if (line_done) ld_seen++;
      if (stall) begin
        check("hold_we", mem_we, 1);
        if (mem_we) begin
          check("hold_addr", mem_addr, s_addr);
          check("hold_data", mem_wdata, s_data);
        end
      end
      stall  = mem_we && !mem_ready;
      s_addr = int'(mem_addr);
      s_data = int'(mem_wdata);
      if (mem_we && mem_ready) begin
        wcount++;
        if (expq.size() == 0) begin
          check("unexpected_write", mem_addr, -1);
        end else begin
          e = expq.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
          if (e.last) chk_ld = 1;
        end
      end
    end
  end

  int w0, ld0, p0, ldbase;
  int rx, ry, rc;

  initial begin
    reset_n = 1'b1; pix_valid = 1'b0;
    pix_x = '0; pix_y = '0; pix_color = '0; pix_last = 1'b0;
    mem_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_clip", clip_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("post_rst_ready", pix_ready, 1);
    check("post_rst_addr", mem_addr, 0);
    check("post_rst_ld", line_done, 0);
    @(posedge clk); #1;
    ldbase = 0;

    // single pixel, fixed latency
    send(3, 2, 8'h5A, 1'b1);
    check("lat_we_early", mem_we, 0);
    @(posedge clk); #1;
    check("lat_we", mem_we, 1);
    check("lat_addr", mem_addr, 1283);
    wait_idle();

    // clipping at the framebuffer edges
    w0 = wcount;
    send(640, 0, 1, 1'b0);
    send(0, 480, 2, 1'b0);
    send(639, 479, 3, 1'b0);
    wait_idle();
    check("clip_cnt_2", clip_cnt, 2);
    check("edge_writes", wcount - w0, 1);

    // clipped last pixel
    w0 = wcount; ld0 = ld_seen;
    send(700, 10, 4, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    check("clip_last_ld", ld_seen - ld0, 1);
    check("clip_last_nowr", wcount - w0, 0);

    // duplicates
    w0 = wcount;
    send(5, 5, 8'h33, 1'b0);
    send(5, 5, 8'h33, 1'b0);
    send(6, 5, 8'h33, 1'b1);
    wait_idle();
    check("dedup_writes", wcount - w0, DEDUP ? 2 : 3);

    // burst into a stalled memory
    ready_fixed = 1'b0;
    p0 = n_push;
    fork
      begin
        for (int i = 0; i < 12; i++) send(10 + i, 100, i, i == 11);
      end
    join_none
    repeat (20) @(posedge clk);
    #1;
    check("burst_accepted", n_push - p0, 9);
    check("burst_ready_low", pix_ready, 0);
    check("burst_we_held", mem_we, 1);
    ready_fixed = 1'b1;
    w0 = wcount;
    repeat (12) @(posedge clk);
    #1;
    check("burst_full_rate", wcount - w0, 12);
    wait fork;
    wait_idle();

    // randomized stream with random backpressure
    rnd_ready = 1'b1;
    rx = 0; ry = 0; rc = 0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 5) != 0) begin
        rx = $urandom_range(0, 700);
        ry = $urandom_range(0, 520);
        rc = $urandom_range(0, 255);
      end
      send(rx, ry, rc, $urandom_range(0, 7) == 0);
    end
    rnd_ready = 1'b0;
    ready_fixed = 1'b1;
    wait_idle();
    check("rnd_queue_drained", expq.size(), 0);
    check("rnd_clip_cnt", clip_cnt, exp_clip);
    check("rnd_line_done", ld_seen - ldbase, exp_lines);

    // reset mid-line with buffered pixels
    ready_fixed = 1'b0;
    for (int i = 0; i < 6; i++) send(20 + i, 7, i, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_we", mem_we, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_clip", clip_cnt, 0);
    check("mid_rst_ld", line_done, 0);
    expq.delete();
    exp_clip = 0; exp_lines = 0; m_dv = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rel_busy", busy, 0);
    check("rel_ready", pix_ready, 1);
    ldbase = ld_seen;
    ready_fixed = 1'b1;
    w0 = wcount;
    repeat (10) @(posedge clk);
    #1;
    check("rel_no_writes", wcount - w0, 0);
    check("rel_we", mem_we, 0);
    check("rel_no_ld", ld_seen - ldbase, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
